// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word-aligned imem requests, pairs in-order
// responses with their PC and hands {pc, inst} to decode through a small FIFO.
package fetch_unit_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_info_t;
endpackage

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] fetch_info,
    output logic        fetch_error
);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {RUN, FLUSH} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] drop_q, drop_d;
    logic [TW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [31:0]   tag_q  [MAX_OUTSTANDING];
    fetch_info_t   fifo_q [FIFO_DEPTH];

    logic          accept;
    logic          resp_ok;
    logic          pop;
    logic          push;
    logic [31:0]   credit;

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
    endfunction

    // Credit counts buffered plus live in-flight fetches; stale ones never reach the FIFO.
    assign credit         = 32'(cnt_q) + 32'(outst_q) - 32'(drop_q);
    assign imem_req_valid = !rst && (32'(outst_q) < 32'(MAX_OUTSTANDING))
                                 && (credit < 32'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign resp_ok        = imem_resp_valid && (outst_q != '0);
    assign out_valid      = (cnt_q != '0);
    assign pop            = out_valid && out_ready;
    assign fetch_info     = fifo_q[rd_ptr_q];
    assign fetch_error    = err_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        outst_d  = outst_q;
        drop_d   = drop_q;
        tag_wr_d = tag_wr_q;
        tag_rd_d = tag_rd_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        push     = 1'b0;

        if (accept) begin
            pc_d     = pc_q + 32'd4;
            tag_wr_d = tag_next(tag_wr_q);
        end
        if (resp_ok) begin
            tag_rd_d = tag_next(tag_rd_q);
            if (state_q == FLUSH) begin
                drop_d = drop_q - OW'(1);
            end else begin
                push = 1'b1;
            end
        end
        outst_d = outst_q + OW'(accept) - OW'(resp_ok);

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);

        // Everything still in flight, including this cycle's accept, belongs to the old path.
        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            drop_d   = outst_d;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            push     = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                err_d = 1'b1;
            end
        end

        state_d = (drop_d != '0) ? FLUSH : RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            outst_q  <= '0;
            drop_q   <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            tag_wr_q <= tag_wr_d;
            tag_rd_q <= tag_rd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // PC tag queue and output buffer storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q  <= '{default: '0};
            fifo_q <= '{default: '0};
        end else begin
            if (accept) begin
                tag_q[tag_wr_q] <= pc_q;
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= '{pc: tag_q[tag_rd_q], inst: imem_resp_data};
            end
        end
    end

    resp_without_request: assert property (
        @(posedge clk) disable iff (rst) imem_resp_valid |-> (outst_q != '0)
    );

endmodule
